// File: rtl/full_adder_4bit.sv
// full_adder_4bit: registered 4-bit ripple-carry adder.
//
// A chain of four 1-bit full-adder cells produces {cout,sum}; the result,
// a two's-complement overflow flag and a zero flag are registered on the
// rising clk edge.
//
// Optional subtract mode is enabled by defining FULL_ADDER_4BIT_SUB_EN.
// It adds a 'sub' input. When sub=1, ~in_b and ~cin enter the chain,
// giving in_a - in_b - cin mod 16; in that mode cout=1 means no borrow.
//
// Valid semantics: there is no ready or backpressure. Operands are taken
// on every edge where in_valid=1. The result appears one edge later with
// out_valid=1, and out_valid is high for exactly that cycle. An edge with
// in_valid=0 holds the result registers and drops out_valid. rst
// overrides in_valid, and the operands of that cycle are discarded.
module full_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       cin,
`ifdef FULL_ADDER_4BIT_SUB_EN
  input  logic       sub,
`endif
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       zero
);

  // Operands as actually seen by the chain (B and carry-in inverted when
  // subtracting).
  logic [3:0] chain_b;
  logic       chain_cin;

`ifdef FULL_ADDER_4BIT_SUB_EN
  // Subtract mode inverts B and the carry-in before the chain.
  always_comb begin
    chain_b   = sub ? ~in_b : in_b;
    chain_cin = sub ? ~cin  : cin;
  end
`else
  // Add-only build: operands pass straight to the chain.
  always_comb begin
    chain_b   = in_b;
    chain_cin = cin;
  end
`endif

  // carry[i] is the carry into cell i; carry[4] is the carry out of bit 3.
  logic [4:0] carry;
  logic [3:0] sum_comb;

  assign carry[0] = chain_cin;

  // Ripple chain of four full-adder cells.
  for (genvar i = 0; i < 4; i++) begin : g_cell
    logic p;
    assign p            = in_a[i] ^ chain_b[i];
    assign sum_comb[i]  = p ^ carry[i];
    assign carry[i + 1] = (in_a[i] & chain_b[i]) | (carry[i] & p);
  end

  logic ovf_comb;
  logic zero_comb;

  // Overflow is the carry into bit 3 disagreeing with the carry out of it.
  // Zero looks only at the four sum bits.
  always_comb begin
    ovf_comb  = carry[3] ^ carry[4];
    zero_comb = (sum_comb == 4'b0000);
  end

  // Result registers: reset clears everything, valid loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= 4'b0000;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      sum       <= sum_comb;
      cout      <= carry[4];
      ovf       <= ovf_comb;
      zero      <= zero_comb;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder_4bit.sv
// tb_full_adder_4bit: directed and random checks of full_adder_4bit
// against an arithmetic reference model. Build with FULL_ADDER_4BIT_SUB_EN
// defined to cover subtract mode as well.
module tb_full_adder_4bit;

  // Clock and reset.
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic       sub_in = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;

  always #5 clk = ~clk;

`ifdef FULL_ADDER_4BIT_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  full_adder_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .cin       (cin),
`ifdef FULL_ADDER_4BIT_SUB_EN
    .sub       (sub_in),
`endif
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are packed as {out_valid, ovf, zero, cout, sum[3:0]}.
  logic [7:0] exp_q[$];

  // Model state: the last held result.
  logic [3:0] m_sum  = 4'h0;
  logic       m_cout = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_zero = 1'b0;

  // Reference model. It works on integers and the signed range, not on a
  // carry chain.
  task automatic model_calc(input logic [3:0] a, input logic [3:0] b,
                            input logic c, input logic s,
                            output logic [3:0] r_sum, output logic r_cout,
                            output logic r_ovf, output logic r_zero);
    int ua, ub, uc, total, sa, sb, st;
    ua = int'(a);
    ub = (s && HAS_SUB) ? 15 - int'(b) : int'(b);
    uc = (s && HAS_SUB) ? 1 - int'(c) : int'(c);
    total  = ua + ub + uc;
    r_sum  = 4'(total % 16);
    r_cout = (total >= 16);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    st = sa + sb + uc;
    r_ovf  = (st > 7) || (st < -8);
    r_zero = ((total % 16) == 0);
  endtask

  // Compare one observed value against one expected value.
  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Driver: apply one cycle of inputs, predict the result, then check all
  // outputs #1 after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic s);
    logic [3:0] ps;
    logic pc, po, pz, pv;
    logic [7:0] e;
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; cin = c; sub_in = s;
    if (r) begin
      m_sum = 4'h0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; pv = 1'b0;
    end else if (v) begin
      model_calc(a, b, c, s, ps, pc, po, pz);
      m_sum = ps; m_cout = pc; m_ovf = po; m_zero = pz; pv = 1'b1;
    end else begin
      pv = 1'b0;
    end
    exp_q.push_back({pv, m_ovf, m_zero, m_cout, m_sum});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp("out_valid", {3'b0, out_valid}, {3'b0, e[7]});
    cmp("ovf",       {3'b0, ovf},       {3'b0, e[6]});
    cmp("zero",      {3'b0, zero},      {3'b0, e[5]});
    cmp("cout",      {3'b0, cout},      {3'b0, e[4]});
    cmp("sum",       sum,               e[3:0]);
  endtask

  // Check the DUT against hand-derived constants from the worked examples.
  task automatic expect_out(input string tag, input logic v, input logic [3:0] s,
                            input logic co, input logic o, input logic z);
    cmp({tag, "_valid"}, {3'b0, out_valid}, {3'b0, v});
    cmp({tag, "_sum"},   sum,               s);
    cmp({tag, "_cout"},  {3'b0, cout},      {3'b0, co});
    cmp({tag, "_ovf"},   {3'b0, ovf},       {3'b0, o});
    cmp({tag, "_zero"},  {3'b0, zero},      {3'b0, z});
  endtask

  // Directed steps followed by a random run.
  initial begin
    // Reset for one edge.
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    expect_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // 1 + 3 + 1 = 5.
    step(1'b0, 1'b1, 4'b0001, 4'b0011, 1'b1, 1'b0);
    expect_out("add_1_3_1", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);

    // Wrap: F + 1 gives sum 0 with carry out and zero set.
    step(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0);
    expect_out("wrap_f_1", 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);

    // Signed overflow: 7 + 1 = 8.
    step(1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 1'b0);
    expect_out("ovf_7_1", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0);

    // Three idle cycles hold the result and drop out_valid.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      expect_out("hold", 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    end

    // Reset takes priority over valid operands.
    step(1'b1, 1'b1, 4'h6, 4'h5, 1'b1, 1'b0);
    expect_out("rst_prio", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back operands: 2+3+0, then 9+9+1.
    step(1'b0, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0);
    expect_out("b2b_first", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h9, 4'h9, 1'b1, 1'b0);
    expect_out("b2b_second", 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);

`ifdef FULL_ADDER_4BIT_SUB_EN
    // 3 - 5 - 0 borrows; 5 - 3 - 1 does not.
    step(1'b0, 1'b1, 4'h3, 4'h5, 1'b0, 1'b1);
    expect_out("sub_3_5", 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h5, 4'h3, 1'b1, 1'b1);
    expect_out("sub_5_3", 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
`endif

    // Random traffic: mostly valid operands, with occasional idles and resets.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 8),
           4'($urandom), 4'($urandom), 1'($urandom),
           HAS_SUB ? 1'($urandom) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound in case something stalls the driver.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d required=finish", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/full_adder_4bit.md
FULL_ADDER_4BIT -- requirements
Module: full_adder_4bit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the single clock of the block.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  operands valid this cycle.
REQ-004 SHALL have port: cin  input  1  carry-in (borrow-in in subtract mode).
REQ-005 SHALL have port: in_a  input  4  operand A, unsigned or two's complement.
REQ-006 SHALL have port: in_b  input  4  operand B, unsigned or two's complement.
REQ-007 SHALL have port: out_valid  output  1  registered result valid.
REQ-008 SHALL have port: sum  output  4  registered sum bits [3:0].
REQ-009 SHALL have port: cout  output  1  registered carry-out from bit 3.
REQ-010 SHALL have port: ovf  output  1  registered two's-complement overflow.
REQ-011 SHALL have port: zero  output  1  registered flag, 1 when sum == 4'b0000.

Function
REQ-012 SHALL compute the result as a ripple chain of four 1-bit full-adder cells; cell i: s = a^b^c, c_out = (a&b)|(c&(a^b)); cell 0 carry-in = cin.
REQ-013 SHALL register {cout,sum} = in_a + in_b + cin (5-bit result, no truncation of carry) on the rising clk edge where in_valid=1.
REQ-014 SHALL set ovf = carry into bit 3 XOR carry out of bit 3 for the same operation.
REQ-015 SHALL set zero = 1 exactly when the registered sum is 0, independent of cout.
REQ-016 SHALL have latency of one cycle: operands sampled at edge N appear on outputs after edge N, with out_valid=1 for that cycle.
REQ-017 SHALL, on an edge with in_valid=0, hold sum, cout, ovf, zero unchanged and drive out_valid=0.
REQ-018 SHALL accept back-to-back operands every cycle with no stall; no backpressure input exists.
REQ-019 SHALL wrap modulo 16 on sum; e.g. 4'hF + 4'h1 + 0 -> sum=0, cout=1.

Reset
REQ-020 SHALL, on an edge with rst=1, clear sum=0, cout=0, ovf=0, zero=0, out_valid=0, regardless of in_valid.
REQ-021 SHALL give rst priority over in_valid when both are high; operands of that cycle are discarded.
REQ-022 SHALL resume normal operation on the first edge with rst=0.

Configuration
REQ-023 SHALL support macro FULL_ADDER_4BIT_SUB_EN; when undefined, the block is add-only and has no sub port.
REQ-024 SHALL, with FULL_ADDER_4BIT_SUB_EN defined, add port sub  input  1  (placed after cin); sub=0 behaves exactly as REQ-013.
REQ-025 SHALL, with sub=1, feed ~in_b to the chain and ~cin as cell-0 carry-in, giving {cout,sum} = in_a + ~in_b + ~cin, i.e. sum = in_a - in_b - cin mod 16; cout=1 means no borrow.
REQ-026 SHALL compute ovf and zero per REQ-014/REQ-015 on the actual chain inputs in subtract mode.

Verification
REQ-027 SHALL check: rst=1 one edge -> out_valid=0, sum=0, cout=0, ovf=0, zero=0.
REQ-028 SHALL check: cin=1, in_a=4'b0001, in_b=4'b0011, in_valid=1 -> next cycle sum=4'b0101, cout=0, ovf=0, zero=0, out_valid=1.
REQ-029 SHALL check: in_a=4'hF, in_b=4'h1, cin=0 -> sum=0, cout=1, zero=1, ovf=0; in_a=4'h7, in_b=4'h1, cin=0 -> sum=4'h8, cout=0, ovf=1.
REQ-030 SHALL check: valid result then in_valid=0 for 3 cycles -> outputs hold last value, out_valid=0; rst=1 with in_valid=1 -> reset values, operands discarded.
REQ-031 SHALL check: back-to-back valid operands 2+3+0, 9+9+1 on consecutive cycles -> sum 4'h5 cout 0, then sum 4'h3 cout 1 on consecutive cycles.
REQ-032 SHALL check (FULL_ADDER_4BIT_SUB_EN defined): sub=1, in_a=3, in_b=5, cin=0 -> sum=4'hE, cout=0; sub=1, in_a=5, in_b=3, cin=1 -> sum=4'h1, cout=1.
